// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared widths and pipeline packet layouts for the core
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int PC_WIDTH    = 12;
  localparam int INSTR_WIDTH = 32;
  localparam int PREG_WIDTH  = 6;
  localparam int AREG_WIDTH  = 5;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_pkt_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [6:0]             c_sig;
    logic [2:0]             alu_sig;
    logic [31:0]            imm;
  } decode_pkt_t;

endpackage

`default_nettype wire

// File: rtl/pipe_buffer.sv
// ---------------------------------------------------------------------------
// pipe_buffer : elastic valid/ready FIFO between pipeline stages, with flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_pkt_t),
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             w_push, w_pop;

  // Handshakes come from registered occupancy only, so no ready/valid loop.
  assign in_ready  = (count_q != c_full);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (w_push && !w_pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (w_pop && !w_push) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

`default_nettype wire
